// File: rtl/seven_segment_scan_controller_if.sv
// seven_segment_scan_controller_if: load handshake and display drive signals of the scan controller
interface seven_segment_scan_controller_if;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        load_valid;
  logic        load_ready;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;
  logic        frame_done;
  modport master (output data_in, dp_in, load_valid, input load_ready, seg_out, dp_out, digit_en, frame_done);
  modport slave (input data_in, dp_in, load_valid, output load_ready, seg_out, dp_out, digit_en, frame_done);
endinterface

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: 4-digit multiplexed hex display with frame-synchronous loads; SEG_BLANK_LEADING_ZERO_EN blanks leading zeros
module seven_segment_scan_controller #(
  parameter int CLK_DIV    = 1000,
  parameter int GAP_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  seven_segment_scan_controller_if.slave bus
);
  localparam int SW = $clog2(CLK_DIV);
  localparam logic [SW-1:0] LAST  = SW'(CLK_DIV - 1);
  localparam logic [SW-1:0] GAP_L = SW'(GAP_CYCLES);
  localparam logic [6:0] SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  typedef enum logic {GAP, DRIVE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] disp_q, disp_d, buf_q, buf_d;
  logic [3:0] dpr_q, dpr_d, pdp_q, pdp_d;
  logic pend_q, pend_d, rdy_q, rdy_d, fd_q, fd_d, dp_q, dp_d;
  logic [6:0] seg_q, seg_d;
  logic [3:0] en_q, en_d, digit;
  logic last, boundary, take, drive, blank;
  always_comb begin
    last = slot_q == LAST;
    boundary = last && idx_q == 2'd3;
    take = bus.load_valid && rdy_q;
    slot_d = last ? '0 : slot_q + 1'b1;
    idx_d = last ? idx_q + 2'd1 : idx_q;
    state_d = last ? (GAP_L == '0 ? DRIVE : GAP) : ((slot_d == GAP_L || GAP_L == '0) ? DRIVE : state_q);
    pend_d = take || (pend_q && !boundary);
    rdy_d = !pend_d;
    buf_d = take ? bus.data_in : buf_q;
    pdp_d = take ? bus.dp_in : pdp_q;
    disp_d = (boundary && pend_q) ? buf_q : disp_q;
    dpr_d = (boundary && pend_q) ? pdp_q : dpr_q;
    fd_d = boundary;
    digit = disp_d[{idx_d, 2'b00} +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    blank = idx_d != 2'd0 && (disp_d >> {idx_d, 2'b00}) == 16'h0;
`else
    blank = 1'b0;
`endif
    drive = state_d == DRIVE;
    seg_d = (drive && !blank) ? SEG[digit] : 7'b0;
    dp_d = drive && dpr_d[idx_d];
    en_d = drive ? 4'b0001 << idx_d : 4'b0000;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= GAP;
      slot_q <= '0;
      idx_q <= '0;
      disp_q <= '0;
      dpr_q <= '0;
      buf_q <= '0;
      pdp_q <= '0;
      pend_q <= 1'b0;
      rdy_q <= 1'b1;
      fd_q <= 1'b0;
      seg_q <= '0;
      dp_q <= 1'b0;
      en_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q <= slot_d;
      idx_q <= idx_d;
      disp_q <= disp_d;
      dpr_q <= dpr_d;
      buf_q <= buf_d;
      pdp_q <= pdp_d;
      pend_q <= pend_d;
      rdy_q <= rdy_d;
      fd_q <= fd_d;
      seg_q <= seg_d;
      dp_q <= dp_d;
      en_q <= en_d;
    end
  end
  assign bus.seg_out = seg_q;
  assign bus.dp_out = dp_q;
  assign bus.digit_en = en_q;
  assign bus.frame_done = fd_q;
  assign bus.load_ready = rdy_q;
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: directed and random loads checked against a frame-level display model
module tb_seven_segment_scan_controller;
  localparam int CD = 8;
  localparam int GP = 2;
  localparam int FR = 4 * CD;
  localparam logic [6:0] SEGT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  seven_segment_scan_controller_if bus ();
  seven_segment_scan_controller #(.CLK_DIV(CD), .GAP_CYCLES(GP)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  logic pend = 1'b0;
  logic [15:0] disp = '0, pbuf = '0;
  logic [3:0] dpv = '0, pdp = '0;
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask
  task automatic check_now();
    int slot, idx;
    bit drive;
    logic [15:0] sh;
    logic [6:0] es;
    logic [3:0] one;
    slot = k % CD;
    idx = (k / CD) % 4;
    drive = slot >= GP;
    sh = disp >> (4 * idx);
    es = SEGT[sh[3:0]];
`ifdef SEG_BLANK_LEADING_ZERO_EN
    if (idx != 0 && sh == 16'h0) es = 7'b0;
`endif
    one = 4'b0001;
    chk("digit_en", 16'(bus.digit_en), drive ? 16'(one << idx) : 16'h0);
    chk("seg_out", 16'(bus.seg_out), drive ? 16'(es) : 16'h0);
    chk("dp_out", 16'(bus.dp_out), drive ? 16'(dpv[idx]) : 16'h0);
    chk("frame_done", 16'(bus.frame_done), 16'(k > 0 && k % FR == 0));
    chk("load_ready", 16'(bus.load_ready), 16'(!pend));
  endtask
  task automatic cyc(bit lv, logic [15:0] d, logic [3:0] p);
    bit take;
    check_now();
    bus.load_valid = lv;
    bus.data_in = d;
    bus.dp_in = p;
    @(posedge clk);
    take = lv && !pend;
    if (k % FR == FR - 1 && pend) begin
      disp = pbuf;
      dpv = pdp;
      pend = 1'b0;
    end
    if (take) begin
      pbuf = d;
      pdp = p;
      pend = 1'b1;
    end
    k++;
    @(negedge clk);
  endtask
  task automatic do_reset(int n);
    rst = 1'b1;
    bus.load_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_seg", 16'(bus.seg_out), 16'h0);
      chk("rst_dp", 16'(bus.dp_out), 16'h0);
      chk("rst_en", 16'(bus.digit_en), 16'h0);
      chk("rst_fd", 16'(bus.frame_done), 16'h0);
      chk("rst_ready", 16'(bus.load_ready), 16'h1);
    end
    rst = 1'b0;
    k = 0;
    pend = 1'b0;
    disp = '0;
    dpv = '0;
  endtask
  initial begin
    bus.data_in = '0;
    bus.dp_in = '0;
    bus.load_valid = 1'b0;
    @(negedge clk);
    do_reset(3);
    repeat (12) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h1234, 4'b0000);
    repeat (60) cyc(1'b1, 16'hABCD, 4'b1010);
    repeat (40) cyc(1'b0, 16'h0, 4'h0);
    while (k % FR != FR - 1) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h00F0, 4'b0100);
    repeat (70) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h0070, 4'b0001);
    repeat (70) cyc(1'b0, 16'h0, 4'h0);
    while (k % FR != 5) cyc(1'b0, 16'h0, 4'h0);
    cyc(1'b1, 16'h5A5A, 4'hF);
    while (k % FR != 2 * CD + 2) cyc(1'b0, 16'h0, 4'h0);
    do_reset(2);
    repeat (40) cyc(1'b0, 16'h0, 4'h0);
    repeat (400) cyc($urandom_range(0, 3) == 0, 16'($urandom), 4'($urandom));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
